// File: rtl/cic_sample_fifo.sv
// cic_sample_fifo: decimates a CIC output stream by sampling it once every
// DECIM_RATIO enabled clocks and queues the captured samples in a small
// first-word fall-through FIFO with a sticky overflow flag.
module cic_sample_fifo #(
    parameter int WIDTH       = 14,
    parameter int DEPTH       = 8,
    parameter int DECIM_RATIO = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         in,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(DECIM_RATIO);

    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM_RATIO - 1);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);

    logic [PW-1:0]    phase;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic capture;
    logic pop;
    logic full;
    logic push;
    logic drop;

    // Capture/pop qualification; a pop frees the slot the capture needs when full.
    always_comb begin
        capture = 1'b0;
        pop     = 1'b0;
        full    = 1'b0;
        push    = 1'b0;
        drop    = 1'b0;
        capture = enable && (phase == PHASE_LAST);
        pop     = (level_q != '0) && out_ready;
        full    = (level_q == LEVEL_FULL);
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;
    end

    // Decimation phase counter: runs while enabled, cleared while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= '0;
        end else if (!enable) begin
            phase <= '0;
        end else if (phase == PHASE_LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracked explicitly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in;
        end
    end

    // Sticky overflow flag; a drop on the same edge beats the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    // Head of FIFO straight from storage; forced to zero when empty so that
    // reset drives out_data low without resetting the array.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_valid = (level_q != '0);
        if (out_valid) begin
            out_data = mem[rd_ptr];
        end
    end

    assign level = level_q;

endmodule
